reorder_buffer: RTL and testbench

REORDER_BUFFER -- requirements
Module: reorder_buffer

---
 rtl/types_pkg.sv | 36 +++
 rtl/reorder_buffer.sv | 223 ++++++++++++++++++++++
 tb/tb_reorder_buffer.sv | 255 +++++++++++++++++++++++++
 3 files changed

// File: rtl/types_pkg.sv
// Shared types for the out-of-order core.
// Contents:
//   ROB_PREG_W_MAX - widest physical register tag a ROB entry can hold
//   rob_entry_t    - one reorder buffer entry (payload plus valid/complete flags)
//   rob_state_e    - reorder buffer control state
//   rob_age()      - distance of a tag from the head; smaller is older.
//                    Reservation stations use it to pick the oldest ready op.
package types_pkg;

  // Entries hold physical tags up to this width. Narrower PREG_W values
  // use the low bits and leave the upper bits at zero.
  localparam int ROB_PREG_W_MAX = 16;

  typedef struct packed {
    logic [4:0]                rd;
    logic [ROB_PREG_W_MAX-1:0] pd_new;
    logic [ROB_PREG_W_MAX-1:0] pd_old;
    logic [31:0]               pc;
    logic                      complete;
    logic                      valid;
  } rob_entry_t;

  typedef enum logic [0:0] {
    IDLE     = 1'b0,
    ROLLBACK = 1'b1
  } rob_state_e;

  // Age of tag relative to head in a ring of 'depth' entries. depth must be
  // a power of two, so masking with depth-1 is a modulo.
  function automatic int unsigned rob_age(input int unsigned tag,
                                          input int unsigned head,
                                          input int unsigned depth);
    return (tag - head) & (depth - 32'd1);
  endfunction

endpackage

// File: rtl/reorder_buffer.sv
// Reorder buffer. It allocates entries in program order, accepts
// out-of-order completions, and retires completed entries from the head in
// order. On a mispredict it walks back from the tail toward the mispredicted
// branch. Each squashed entry is emitted so rename can restore its map and
// free its register.
// Ports:
//   clk, reset_n                       clock, async active-low reset
//   alloc_valid/alloc_ready, alloc_*   dispatch handshake and payload
//   alloc_tag                          index the next accepted entry gets
//   cpl_valid/cpl_tag                  NUM_CPL completion ports
//   mispredict_valid/mispredict_tag    branch whose younger entries are squashed
//   commit_valid/commit_ready, commit_* head retire handshake and payload
//   rollback_valid, rollback_*         entry squashed this cycle
//   full, empty, count                 occupancy
module reorder_buffer
  import types_pkg::*;
#(
  parameter int DEPTH   = 16,
  parameter int NUM_CPL = 2,
  parameter int PREG_W  = 8,
  localparam int TAG_W  = $clog2(DEPTH)
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic                     alloc_valid,
  output logic                     alloc_ready,
  input  logic [4:0]               alloc_rd,
  input  logic [PREG_W-1:0]        alloc_pd_new,
  input  logic [PREG_W-1:0]        alloc_pd_old,
  input  logic [31:0]              alloc_pc,
  output logic [TAG_W-1:0]         alloc_tag,
  input  logic [NUM_CPL-1:0]       cpl_valid,
  input  logic [NUM_CPL*TAG_W-1:0] cpl_tag,
  input  logic                     mispredict_valid,
  input  logic [TAG_W-1:0]         mispredict_tag,
  output logic                     commit_valid,
  input  logic                     commit_ready,
  output logic [4:0]               commit_rd,
  output logic [PREG_W-1:0]        commit_pd_new,
  output logic [PREG_W-1:0]        commit_pd_old,
  output logic [31:0]              commit_pc,
  output logic                     rollback_valid,
  output logic [4:0]               rollback_rd,
  output logic [PREG_W-1:0]        rollback_pd_new,
  output logic [PREG_W-1:0]        rollback_pd_old,
  output logic                     full,
  output logic                     empty,
  output logic [TAG_W:0]           count
);

  localparam logic [TAG_W-1:0] IDX_ONE = TAG_W'(1);
  localparam logic [TAG_W:0]   PTR_ONE = (TAG_W+1)'(1);

  rob_entry_t        r_entries [DEPTH];
  logic [TAG_W:0]    r_head;
  logic [TAG_W:0]    r_tail;
  rob_state_e        r_state;
  rob_state_e        w_state_nxt;
  logic [TAG_W-1:0]  r_target;
  logic [TAG_W-1:0]  w_target_nxt;

  logic [TAG_W-1:0]  w_head_idx;
  logic [TAG_W-1:0]  w_tail_idx;
  logic [TAG_W-1:0]  w_last_idx;
  logic              w_full;
  logic              w_empty;
  logic              w_alloc_fire;
  logic              w_commit_valid;
  logic              w_commit_fire;
  logic              w_rollback_fire;
  logic              w_mp_hit;
  logic [31:0]       w_age_mp;
  logic [31:0]       w_age_tgt;
  logic [TAG_W-1:0]  w_cpl_idx [NUM_CPL];
  rob_entry_t        w_alloc_e;

  // Pointer decode, occupancy flags and handshakes.
  always_comb begin
    w_head_idx     = r_head[TAG_W-1:0];
    w_tail_idx     = r_tail[TAG_W-1:0];
    w_last_idx     = w_tail_idx - IDX_ONE;
    w_full         = (w_head_idx == w_tail_idx) && (r_head[TAG_W] != r_tail[TAG_W]);
    w_empty        = (r_head == r_tail);
    w_alloc_fire   = alloc_valid && !w_full && (r_state == IDLE);
    w_commit_valid = (r_state == IDLE) && r_entries[w_head_idx].valid
                     && r_entries[w_head_idx].complete;
    w_commit_fire  = w_commit_valid && commit_ready;
    w_mp_hit       = mispredict_valid && r_entries[mispredict_tag].valid;
    w_age_mp       = rob_age(32'(mispredict_tag), 32'(w_head_idx), 32'(DEPTH));
    w_age_tgt      = rob_age(32'(r_target), 32'(w_head_idx), 32'(DEPTH));
    for (int p = 0; p < NUM_CPL; p++) begin
      w_cpl_idx[p] = cpl_tag[p*TAG_W +: TAG_W];
    end
  end

  // Build the entry written at the tail. Payload bits above PREG_W stay zero.
  always_comb begin
    w_alloc_e                    = '0;
    w_alloc_e.rd                 = alloc_rd;
    w_alloc_e.pd_new[PREG_W-1:0] = alloc_pd_new;
    w_alloc_e.pd_old[PREG_W-1:0] = alloc_pd_old;
    w_alloc_e.pc                 = alloc_pc;
    w_alloc_e.valid              = 1'b1;
    w_alloc_e.complete           = 1'b0;
  end

  // Next-state logic for the IDLE/ROLLBACK walk and its target tag.
  always_comb begin
    w_state_nxt     = r_state;
    w_target_nxt    = r_target;
    w_rollback_fire = 1'b0;
    case (r_state)
      IDLE: begin
        if (w_mp_hit) begin
          w_state_nxt  = ROLLBACK;
          w_target_nxt = mispredict_tag;
        end else begin
          w_state_nxt  = IDLE;
        end
      end
      ROLLBACK: begin
        // The walk stops once the branch itself is the youngest entry.
        w_rollback_fire = (w_last_idx != r_target);
        if (w_mp_hit && (w_age_mp < w_age_tgt)) begin
          // An older branch mispredicted, so keep walking toward it.
          w_state_nxt  = ROLLBACK;
          w_target_nxt = mispredict_tag;
        end else if (!w_rollback_fire) begin
          w_state_nxt  = IDLE;
        end else begin
          w_state_nxt  = ROLLBACK;
        end
      end
      default: begin
        w_state_nxt     = IDLE;
        w_target_nxt    = r_target;
        w_rollback_fire = 1'b0;
      end
    endcase
  end

  // Entry storage: allocate, mark complete, clear on commit or squash.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        r_entries[i] <= '0;
      end
    end else begin
      if (w_alloc_fire) begin
        r_entries[w_tail_idx] <= w_alloc_e;
      end
      // A completion to an empty slot is stale and dropped.
      for (int p = 0; p < NUM_CPL; p++) begin
        if (cpl_valid[p] && r_entries[w_cpl_idx[p]].valid) begin
          r_entries[w_cpl_idx[p]].complete <= 1'b1;
        end
      end
      // The clears come last so that they win over a completion to the same entry.
      if (w_commit_fire) begin
        r_entries[w_head_idx] <= '0;
      end
      if (w_rollback_fire) begin
        r_entries[w_last_idx] <= '0;
      end
    end
  end

  // Head/tail pointers, control state and rollback target.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_head   <= '0;
      r_tail   <= '0;
      r_state  <= IDLE;
      r_target <= '0;
    end else begin
      r_state  <= w_state_nxt;
      r_target <= w_target_nxt;
      if (w_commit_fire) begin
        r_head <= r_head + PTR_ONE;
      end
      // Allocation is blocked in ROLLBACK, so at most one of these fires.
      if (w_alloc_fire) begin
        r_tail <= r_tail + PTR_ONE;
      end else if (w_rollback_fire) begin
        r_tail <= r_tail - PTR_ONE;
      end
    end
  end

  // Output drive. Payloads read as zero when their valid is low.
  always_comb begin
    alloc_ready     = !w_full && (r_state == IDLE);
    alloc_tag       = w_tail_idx;
    full            = w_full;
    empty           = w_empty;
    count           = r_tail - r_head;
    commit_valid    = w_commit_valid;
    rollback_valid  = w_rollback_fire;
    commit_rd       = 5'd0;
    commit_pd_new   = {PREG_W{1'b0}};
    commit_pd_old   = {PREG_W{1'b0}};
    commit_pc       = 32'd0;
    rollback_rd     = 5'd0;
    rollback_pd_new = {PREG_W{1'b0}};
    rollback_pd_old = {PREG_W{1'b0}};
    if (w_commit_valid) begin
      commit_rd     = r_entries[w_head_idx].rd;
      commit_pd_new = r_entries[w_head_idx].pd_new[PREG_W-1:0];
      commit_pd_old = r_entries[w_head_idx].pd_old[PREG_W-1:0];
      commit_pc     = r_entries[w_head_idx].pc;
    end else begin
      commit_rd     = 5'd0;
    end
    if (w_rollback_fire) begin
      rollback_rd     = r_entries[w_last_idx].rd;
      rollback_pd_new = r_entries[w_last_idx].pd_new[PREG_W-1:0];
      rollback_pd_old = r_entries[w_last_idx].pd_old[PREG_W-1:0];
    end else begin
      rollback_rd     = 5'd0;
    end
  end

endmodule

// File: tb/tb_reorder_buffer.sv
// Directed self-checking bench for reorder_buffer with DEPTH=8 and NUM_CPL=2.
// Inputs are driven 1 time unit after the rising edge, and outputs are
// sampled at that same point, before the next edge.
module tb_reorder_buffer;

  localparam int DEPTH   = 8;
  localparam int NUM_CPL = 2;
  localparam int PREG_W  = 8;
  localparam int TAG_W   = 3;

  logic                     clk = 1'b0;
  logic                     reset_n;
  logic                     alloc_valid;
  logic                     alloc_ready;
  logic [4:0]               alloc_rd;
  logic [PREG_W-1:0]        alloc_pd_new;
  logic [PREG_W-1:0]        alloc_pd_old;
  logic [31:0]              alloc_pc;
  logic [TAG_W-1:0]         alloc_tag;
  logic [NUM_CPL-1:0]       cpl_valid;
  logic [NUM_CPL*TAG_W-1:0] cpl_tag;
  logic                     mispredict_valid;
  logic [TAG_W-1:0]         mispredict_tag;
  logic                     commit_valid;
  logic                     commit_ready;
  logic [4:0]               commit_rd;
  logic [PREG_W-1:0]        commit_pd_new;
  logic [PREG_W-1:0]        commit_pd_old;
  logic [31:0]              commit_pc;
  logic                     rollback_valid;
  logic [4:0]               rollback_rd;
  logic [PREG_W-1:0]        rollback_pd_new;
  logic [PREG_W-1:0]        rollback_pd_old;
  logic                     full;
  logic                     empty;
  logic [TAG_W:0]           count;

  int n_checks = 0;
  int n_errors = 0;
  int seq = 0;
  logic [4:0]  exp_rd  [DEPTH];
  logic [7:0]  exp_pdn [DEPTH];
  logic [7:0]  exp_pdo [DEPTH];
  logic [31:0] exp_pc  [DEPTH];

  reorder_buffer #(.DEPTH(DEPTH), .NUM_CPL(NUM_CPL), .PREG_W(PREG_W)) dut (
    .clk(clk), .reset_n(reset_n),
    .alloc_valid(alloc_valid), .alloc_ready(alloc_ready),
    .alloc_rd(alloc_rd), .alloc_pd_new(alloc_pd_new), .alloc_pd_old(alloc_pd_old),
    .alloc_pc(alloc_pc), .alloc_tag(alloc_tag),
    .cpl_valid(cpl_valid), .cpl_tag(cpl_tag),
    .mispredict_valid(mispredict_valid), .mispredict_tag(mispredict_tag),
    .commit_valid(commit_valid), .commit_ready(commit_ready),
    .commit_rd(commit_rd), .commit_pd_new(commit_pd_new), .commit_pd_old(commit_pd_old),
    .commit_pc(commit_pc),
    .rollback_valid(rollback_valid), .rollback_rd(rollback_rd),
    .rollback_pd_new(rollback_pd_new), .rollback_pd_old(rollback_pd_old),
    .full(full), .empty(empty), .count(count)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_reset();
    reset_n = 1'b0;
    step();
    reset_n = 1'b1;
    step();
  endtask

  // Allocate one entry whose payload is derived from seq; expect it at exp_tag.
  task automatic do_alloc(input int exp_tag);
    check_eq("alloc_tag", 32'(alloc_tag), 32'(exp_tag));
    check_eq("alloc_ready", 32'(alloc_ready), 32'd1);
    alloc_rd     = 5'(seq);
    alloc_pd_new = 8'(64 + seq);
    alloc_pd_old = 8'(128 + seq);
    alloc_pc     = 32'(4096 + 4 * seq);
    exp_rd[exp_tag]  = 5'(seq);
    exp_pdn[exp_tag] = 8'(64 + seq);
    exp_pdo[exp_tag] = 8'(128 + seq);
    exp_pc[exp_tag]  = 32'(4096 + 4 * seq);
    seq++;
    alloc_valid = 1'b1;
    step();
    alloc_valid = 1'b0;
  endtask

  task automatic complete2(input int t0, input int t1);
    cpl_valid = 2'b11;
    cpl_tag   = {3'(t1), 3'(t0)};
    step();
    cpl_valid = 2'b00;
  endtask

  task automatic complete1(input int t0);
    cpl_valid = 2'b01;
    cpl_tag   = {3'd0, 3'(t0)};
    step();
    cpl_valid = 2'b00;
  endtask

  task automatic commit_expect(input int t);
    check_eq("commit_valid", 32'(commit_valid), 32'd1);
    check_eq("commit_rd", 32'(commit_rd), 32'(exp_rd[t]));
    check_eq("commit_pd_old", 32'(commit_pd_old), 32'(exp_pdo[t]));
    check_eq("commit_pc", commit_pc, exp_pc[t]);
    commit_ready = 1'b1;
    step();
    commit_ready = 1'b0;
  endtask

  task automatic rollback_expect(input int t);
    check_eq("rollback_valid", 32'(rollback_valid), 32'd1);
    check_eq("rollback_rd", 32'(rollback_rd), 32'(exp_rd[t]));
    check_eq("rollback_pd_new", 32'(rollback_pd_new), 32'(exp_pdn[t]));
    check_eq("rollback_pd_old", 32'(rollback_pd_old), 32'(exp_pdo[t]));
    check_eq("rb_alloc_ready", 32'(alloc_ready), 32'd0);
    check_eq("rb_commit_valid", 32'(commit_valid), 32'd0);
    step();
  endtask

  task automatic mispredict(input int t);
    mispredict_valid = 1'b1;
    mispredict_tag   = 3'(t);
    step();
    mispredict_valid = 1'b0;
  endtask

  initial begin
    reset_n = 1'b0; alloc_valid = 1'b0; alloc_rd = 5'd0; alloc_pd_new = 8'd0;
    alloc_pd_old = 8'd0; alloc_pc = 32'd0; cpl_valid = 2'b00; cpl_tag = 6'd0;
    mispredict_valid = 1'b0; mispredict_tag = 3'd0; commit_ready = 1'b0;
    #2;
    // Outputs while held in reset.
    check_eq("rst_empty", 32'(empty), 32'd1);
    check_eq("rst_alloc_ready", 32'(alloc_ready), 32'd1);
    check_eq("rst_full", 32'(full), 32'd0);
    check_eq("rst_count", 32'(count), 32'd0);
    check_eq("rst_alloc_tag", 32'(alloc_tag), 32'd0);
    check_eq("rst_commit_valid", 32'(commit_valid), 32'd0);
    check_eq("rst_rollback_valid", 32'(rollback_valid), 32'd0);
    step(); step();
    reset_n = 1'b1;
    step();

    // Fill all eight entries, then check that a ninth alloc is held off.
    for (int i = 0; i < 8; i++) do_alloc(i);
    check_eq("fill_full", 32'(full), 32'd1);
    check_eq("fill_alloc_ready", 32'(alloc_ready), 32'd0);
    check_eq("fill_count", 32'(count), 32'd8);
    alloc_valid = 1'b1; alloc_pd_old = 8'hEE;
    step();
    alloc_valid = 1'b0;
    check_eq("ninth_count", 32'(count), 32'd8);
    check_eq("ninth_alloc_tag", 32'(alloc_tag), 32'd0);

    // Completions arrive out of order; commits still retire 0, 1, 2 in order.
    complete2(2, 1);
    check_eq("ooo_no_commit", 32'(commit_valid), 32'd0);
    complete1(0);
    commit_expect(0); commit_expect(1); commit_expect(2);
    check_eq("ooo_stall", 32'(commit_valid), 32'd0);
    check_eq("ooo_count", 32'(count), 32'd5);

    // Wrap-around: move head=tail to 6, then allocate 6, 7, 0, 1.
    pulse_reset();
    for (int i = 0; i < 6; i++) do_alloc(i);
    complete2(0, 1); complete2(2, 3); complete2(4, 5);
    for (int i = 0; i < 6; i++) commit_expect(i);
    check_eq("wrap_empty0", 32'(empty), 32'd1);
    do_alloc(6); do_alloc(7); do_alloc(0); do_alloc(1);
    check_eq("wrap_count", 32'(count), 32'd4);
    complete2(6, 6);
    complete2(7, 0);
    complete1(1);
    commit_expect(6); commit_expect(7); commit_expect(0); commit_expect(1);
    check_eq("wrap_empty", 32'(empty), 32'd1);
    check_eq("wrap_count0", 32'(count), 32'd0);
    check_eq("wrap_tail", 32'(alloc_tag), 32'd2);

    // Rollback: six entries, mispredict at 2 squashes 5, 4, 3.
    pulse_reset();
    for (int i = 0; i < 6; i++) do_alloc(i);
    complete1(0);
    mispredict(6);
    check_eq("mp_invalid_ignored", 32'(alloc_ready), 32'd1);
    check_eq("mp_invalid_no_rb", 32'(rollback_valid), 32'd0);
    mispredict(2);
    rollback_expect(5); rollback_expect(4); rollback_expect(3);
    check_eq("rb_done_valid", 32'(rollback_valid), 32'd0);
    check_eq("rb_done_still_busy", 32'(alloc_ready), 32'd0);
    step();
    check_eq("rb_idle_ready", 32'(alloc_ready), 32'd1);
    check_eq("rb_alloc_tag", 32'(alloc_tag), 32'd3);
    check_eq("rb_count", 32'(count), 32'd3);
    check_eq("rb_commit_resume", 32'(commit_valid), 32'd1);

    // Retarget: mispredict at 5, then an older mispredict at 1 during the walk.
    pulse_reset();
    for (int i = 0; i < 7; i++) do_alloc(i);
    mispredict(5);
    mispredict_valid = 1'b1; mispredict_tag = 3'd1;
    rollback_expect(6);
    mispredict_valid = 1'b0;
    rollback_expect(5); rollback_expect(4); rollback_expect(3); rollback_expect(2);
    check_eq("rt_done_valid", 32'(rollback_valid), 32'd0);
    step();
    check_eq("rt_alloc_tag", 32'(alloc_tag), 32'd2);
    check_eq("rt_count", 32'(count), 32'd2);

    // A mispredict on the youngest entry takes exactly one ROLLBACK cycle.
    mispredict(1);
    check_eq("young_no_rb", 32'(rollback_valid), 32'd0);
    check_eq("young_busy", 32'(alloc_ready), 32'd0);
    step();
    check_eq("young_idle", 32'(alloc_ready), 32'd1);
    check_eq("young_tag", 32'(alloc_tag), 32'd2);

    // Assert reset in the middle of a walk.
    for (int i = 2; i < 6; i++) do_alloc(i);
    mispredict(1);
    rollback_expect(5);
    check_eq("mid_rb_active", 32'(rollback_valid), 32'd1);
    reset_n = 1'b0;
    #1;
    check_eq("mid_rst_empty", 32'(empty), 32'd1);
    check_eq("mid_rst_rb", 32'(rollback_valid), 32'd0);
    check_eq("mid_rst_count", 32'(count), 32'd0);
    step();
    reset_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      check_eq("post_rst_rb", 32'(rollback_valid), 32'd0);
      step();
    end
    check_eq("post_rst_tag", 32'(alloc_tag), 32'd0);
    check_eq("post_rst_ready", 32'(alloc_ready), 32'd1);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
